// File: rtl/rsg_pkg.sv
`default_nettype none
// ============================================================================
// rsg_pkg : phase/state encodings and decode helpers for the READY-SET-GO responder
// Rev 1.0
// ============================================================================
package rsg_pkg;

  typedef enum logic [2:0] {
    READY = 3'b001,
    SET   = 3'b010,
    GO    = 3'b100
  } phase_t;

  typedef logic [3:0] resp_state_t;

  localparam resp_state_t WAIT_READY = 4'b0001;
  localparam resp_state_t WAIT_SET   = 4'b0010;
  localparam resp_state_t WAIT_GO    = 4'b0100;
  localparam resp_state_t ERROR      = 4'b1000;

  function automatic logic [2:0] awaited_phase(input resp_state_t s);
    case (s)
      WAIT_READY: return READY;
      WAIT_SET:   return SET;
      WAIT_GO:    return GO;
      default:    return 3'b000;
    endcase
  endfunction

  // A repeat of the phase just accepted is tolerated up to the stall limit.
  function automatic logic [2:0] pred_phase(input resp_state_t s);
    case (s)
      WAIT_READY: return GO;
      WAIT_SET:   return READY;
      WAIT_GO:    return SET;
      default:    return 3'b000;
    endcase
  endfunction

  function automatic resp_state_t next_wait_state(input resp_state_t s);
    case (s)
      WAIT_READY: return WAIT_SET;
      WAIT_SET:   return WAIT_GO;
      WAIT_GO:    return WAIT_READY;
      default:    return ERROR;
    endcase
  endfunction

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v != 3'b000) && ((v & (v - 3'b001)) == 3'b000);
  endfunction

endpackage : rsg_pkg
`default_nettype wire

// File: rtl/rsg_stall_timer.sv
`default_nettype none
// ============================================================================
// rsg_stall_timer : counts consecutive predecessor-phase repeats
// Rev 1.0
// ============================================================================
module rsg_stall_timer #(
  parameter int TIMEOUT = 4
) (
  input  logic clock,
  input  logic resetN,
  input  logic inc,
  input  logic clr,
  input  logic enable,
  output logic timeout
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] c_limit = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] c_last  = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (enable && inc && (r_count != c_limit)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Flags the increment that brings the count to TIMEOUT, so the error lands one cycle after the sample.
  assign timeout = enable && inc && (r_count == c_last);

endmodule : rsg_stall_timer
`default_nettype wire

// File: rtl/ready_set_go_responder.sv
`default_nettype none
// ============================================================================
// ready_set_go_responder : tracks READY->SET->GO laps, acks phases, flags errors
// Rev 1.0
// ============================================================================
module ready_set_go_responder
  import rsg_pkg::*;
#(
  parameter int LAP_W   = 8,
  parameter int TIMEOUT = 4
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             get_ready,
  input  logic             get_set,
  input  logic             get_going,
  input  logic             enable,
  input  logic             clear_err,
  output logic             ack,
  output logic [2:0]       expected_phase,
  output logic [LAP_W-1:0] lap_count,
  output logic             lap_wrap,
  output logic             phase_err,
  output logic             onehot_err,
  output logic             stall_err
);

  resp_state_t      r_state;
  logic             r_ack;
  logic [LAP_W-1:0] r_lap;
  logic             r_wrap;
  logic             r_phase_err;
  logic             r_onehot_err;
  logic             r_stall_err;

  resp_state_t w_state_next;
  logic [2:0]  w_phase;
  logic        w_onehot;
  logic        w_inc;
  logic        w_timeout;
  logic        w_tmr_clr;
  logic        w_ack;
  logic        w_lap_inc;
  logic        w_set_phase;
  logic        w_set_onehot;
  logic        w_set_stall;
  logic        w_clear;

  assign w_phase  = {get_going, get_set, get_ready};
  assign w_onehot = is_onehot3(w_phase);
  assign w_inc    = enable && w_onehot && (w_phase == pred_phase(r_state));

  rsg_stall_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_stall_timer (
    .clock   (clock),
    .resetN  (resetN),
    .inc     (w_inc),
    .clr     (w_tmr_clr),
    .enable  (enable),
    .timeout (w_timeout)
  );

  always_comb begin
    w_state_next = r_state;
    w_ack        = 1'b0;
    w_lap_inc    = 1'b0;
    w_set_phase  = 1'b0;
    w_set_onehot = 1'b0;
    w_set_stall  = 1'b0;
    w_clear      = 1'b0;
    w_tmr_clr    = 1'b0;
    case (r_state)
      WAIT_READY, WAIT_SET, WAIT_GO: begin
        if (enable) begin
          if (!w_onehot) begin
            w_set_onehot = 1'b1;
            w_state_next = ERROR;
          end else if (w_phase == awaited_phase(r_state)) begin
            w_state_next = next_wait_state(r_state);
            w_ack        = 1'b1;
            w_tmr_clr    = 1'b1;
            w_lap_inc    = (r_state == WAIT_GO);
          end else if (w_phase == pred_phase(r_state)) begin
            if (w_timeout) begin
              w_set_stall  = 1'b1;
              w_state_next = ERROR;
            end
          end else begin
            w_set_phase  = 1'b1;
            w_state_next = ERROR;
          end
        end
      end
      ERROR: begin
        if (clear_err) begin
          w_state_next = WAIT_READY;
          w_clear      = 1'b1;
          w_tmr_clr    = 1'b1;
        end
      end
      default: w_state_next = ERROR;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state      <= WAIT_READY;
      r_ack        <= 1'b0;
      r_lap        <= '0;
      r_wrap       <= 1'b0;
      r_phase_err  <= 1'b0;
      r_onehot_err <= 1'b0;
      r_stall_err  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ack   <= w_ack;
      r_wrap  <= w_lap_inc && (r_lap == {LAP_W{1'b1}});
      if (w_lap_inc) begin
        r_lap <= r_lap + 1'b1;
      end
      if (w_clear) begin
        r_phase_err  <= 1'b0;
        r_onehot_err <= 1'b0;
        r_stall_err  <= 1'b0;
      end else begin
        r_phase_err  <= r_phase_err  | w_set_phase;
        r_onehot_err <= r_onehot_err | w_set_onehot;
        r_stall_err  <= r_stall_err  | w_set_stall;
      end
    end
  end

  // The low three one-hot state bits double as the awaited phase; ERROR reads as 000.
  assign expected_phase = r_state[2:0];
  assign ack            = r_ack;
  assign lap_count      = r_lap;
  assign lap_wrap       = r_wrap;
  assign phase_err      = r_phase_err;
  assign onehot_err     = r_onehot_err;
  assign stall_err      = r_stall_err;

endmodule : ready_set_go_responder
`default_nettype wire

// File: doc/ready_set_go_responder.md
READY_SET_GO_RESPONDER -- requirements
Module: ready_set_go_responder

Interface
REQ-001 The block SHALL take parameter LAP_W, default 8, as the lap counter width.
REQ-002 The block SHALL take parameter TIMEOUT, default 4, as the maximum number of consecutive cycles a phase may repeat before a stall error.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port clock: input, 1 bit, rising-edge clock.
REQ-005 Port resetN: input, 1 bit, asynchronous active-low reset.
REQ-006 Port get_ready: input, 1 bit, initiator READY phase strobe.
REQ-007 Port get_set: input, 1 bit, initiator SET phase strobe.
REQ-008 Port get_going: input, 1 bit, initiator GO phase strobe.
REQ-009 Port enable: input, 1 bit, sample the phase inputs this cycle.
REQ-010 Port clear_err: input, 1 bit, single-cycle pulse that leaves ERROR.
REQ-011 Port ack: output, 1 bit, one-cycle pulse when an expected phase is accepted.
REQ-012 Port expected_phase: output, 3 bits, one-hot phase awaited: 001 READY, 010 SET, 100 GO; 000 while in ERROR.
REQ-013 Port lap_count: output, LAP_W bits, number of completed READY->SET->GO laps.
REQ-014 Port lap_wrap: output, 1 bit, one-cycle pulse when lap_count wraps.
REQ-015 Port phase_err: output, 1 bit, sticky flag for a legal but out-of-order phase.
REQ-016 Port onehot_err: output, 1 bit, sticky flag for a phase vector that is not one-hot.
REQ-017 Port stall_err: output, 1 bit, sticky flag for a timeout.

Function
REQ-018 The phase vector SHALL be {get_going, get_set, get_ready}, and the block SHALL sample it only when enable=1.
REQ-019 The FSM states SHALL be WAIT_READY, WAIT_SET, WAIT_GO and ERROR, one-hot encoded.
REQ-020 Each WAIT_x state SHALL have a predecessor phase: WAIT_READY->GO, WAIT_SET->READY, WAIT_GO->SET.
REQ-021 In WAIT_x, when the sample equals x, the FSM SHALL advance to the next state, assert ack the following cycle, and zero the stall counter.
REQ-022 In WAIT_x, when the sample equals the predecessor phase, the FSM SHALL hold state and increment the stall counter.
REQ-023 When the stall counter reaches TIMEOUT, the block SHALL set stall_err and enter ERROR.
REQ-024 In WAIT_x, when the sample is the remaining legal phase, the block SHALL set phase_err and enter ERROR.
REQ-025 When the sample is 000 or has more than one bit set, the block SHALL set onehot_err and enter ERROR; this takes priority over phase_err.
REQ-026 When enable=0, the block SHALL hold state, stall counter and flags, and SHALL keep ack low.
REQ-027 On each GO acceptance, lap_count SHALL increment modulo 2^LAP_W.
REQ-028 On the transition from 2^LAP_W-1 to 0, lap_wrap SHALL pulse in the same cycle as ack.
REQ-029 ERROR SHALL be held until clear_err=1, which returns the FSM to WAIT_READY, clears all three error flags and the stall counter, and keeps lap_count.
REQ-030 When clear_err and an error condition occur in the same cycle, clear SHALL win and the inputs in that cycle SHALL be ignored.
REQ-031 In any state other than ERROR, clear_err SHALL be a no-op.
REQ-032 All outputs SHALL be registered, with a latency of 1 cycle from sample to ack or flag.
REQ-033 The next-state decode SHALL contain no latches, and unlisted state encodings SHALL recover to ERROR.

Reset
REQ-034 While resetN=0, the block SHALL force state to WAIT_READY, expected_phase=001, ack=0, lap_count=0, lap_wrap=0, all error flags to 0 and the stall counter to 0.
REQ-035 An asynchronous reset during a lap SHALL abandon the lap with no ack.

Structure
REQ-036 Package rsg_pkg SHALL hold phase_t (enum logic [2:0]: READY=001, SET=010, GO=100) and resp_state_t (one-hot 4-bit).
REQ-037 Sub-module rsg_stall_timer SHALL implement the stall counter, with inputs inc, clr and enable and output timeout at count==TIMEOUT.

Verification
REQ-038 Reset, then three laps of 001,010,100 with enable=1 -> ack every cycle, lap_count=3, no errors.
REQ-039 LAP_W=2, five laps -> lap_wrap pulses once, at the 4th GO; final lap_count=1.
REQ-040 Sequence 001, then 100 -> phase_err=1, expected_phase=000; then clear_err -> expected_phase=001, phase_err=0.
REQ-041 Sequence 001, then 011 -> onehot_err=1 and phase_err=0.
REQ-042 Sequence 001, then 001 repeated 4 times (TIMEOUT=4) -> stall_err on the 4th repeat; 3 repeats followed by 010 -> accepted with ack.
REQ-043 enable=0 during a lap with garbage inputs -> no state change; resetN pulsed mid-lap -> WAIT_READY and lap_count=0.
